// File: rtl/output_pkg.sv
// output_pkg: shared constants, FSM state type and bipolar score helper for the output stages.
package output_pkg;
  localparam int VEC_LEN   = 256;
  localparam int NUM_CLASS = 10;
  localparam int DATA_W    = 9;
  localparam int IDX_W     = 4;
  typedef enum logic {IDLE, ACC} state_e;
  // Popcount p of a length-vec_len XNOR vector maps to the bipolar dot product 2p - vec_len.
  function automatic int bipolar(input int p, input int vec_len);
    return 2 * p - vec_len;
  endfunction
endpackage

// File: rtl/output_argmax.sv
// output_argmax: streams NUM_CLASS popcount scores per frame and emits the winning class
// with its bipolar score as a one-cycle pulse; ties resolve to the lowest index.
module output_argmax #(
  parameter int DATA_W    = output_pkg::DATA_W,
  parameter int VEC_LEN   = output_pkg::VEC_LEN,
  parameter int NUM_CLASS = output_pkg::NUM_CLASS,
  parameter int IDX_W     = output_pkg::IDX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     data_in_valid,
  input  logic                     frame_clr,
  output logic [IDX_W-1:0]         class_out,
  output logic signed [DATA_W:0]   score_out,
  output logic                     class_out_valid,
  output logic                     busy
);
  output_pkg::state_e state_q, state_d;
  logic [DATA_W-1:0] best_q, best_d;
  logic [IDX_W-1:0] idx_q, idx_d, cnt_q, cnt_d, class_q, class_d;
  logic signed [DATA_W:0] score_q, score_d;
  logic valid_q, take, last, upd, done;
  always_comb begin
    take    = data_in_valid && !frame_clr;
    last    = cnt_q == IDX_W'(NUM_CLASS - 1);
    done    = take && last;
    // In IDLE cnt is 0, so the first score loads with index cnt_q unconditionally.
    upd     = state_q == output_pkg::IDLE || data_in > best_q;
    best_d  = take && upd ? data_in : best_q;
    idx_d   = take && upd ? cnt_q : idx_q;
    cnt_d   = frame_clr || done ? '0 : take ? cnt_q + IDX_W'(1) : cnt_q;
    state_d = frame_clr || done ? output_pkg::IDLE : take ? output_pkg::ACC : state_q;
    class_d = done ? idx_d : class_q;
    score_d = done ? (DATA_W+1)'(output_pkg::bipolar(int'(best_d), VEC_LEN)) : score_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= output_pkg::IDLE;
    else        state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else begin
      best_q <= best_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_q <= '0;
      score_q <= '0;
      valid_q <= 1'b0;
    end else begin
      class_q <= class_d;
      score_q <= score_d;
      valid_q <= done;
    end
  end
  assign class_out       = class_q;
  assign score_out       = score_q;
  assign class_out_valid = valid_q;
  assign busy            = state_q == output_pkg::ACC;
endmodule

// File: tb/tb_output_argmax.sv
// tb_output_argmax: table-driven frames plus hand-written abort, reset and back-to-back sequences.
module tb_output_argmax;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [8:0] data_in = '0;
  logic data_in_valid = 1'b0;
  logic frame_clr = 1'b0;
  logic [3:0] class_out;
  logic signed [9:0] score_out;
  logic class_out_valid, busy;
  int n_chk = 0, n_fail = 0, pulses = 0;

  output_argmax dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(data_in_valid),
    .frame_clr(frame_clr), .class_out(class_out), .score_out(score_out),
    .class_out_valid(class_out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sc[10];
    int gap;
    int cls;
    int scr;
  } vec_t;
  vec_t tv[6];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    pulses += int'(class_out_valid);
  endtask

  task automatic run_frame(input int sc[10], input int gap, input int cls, input int scr);
    int p0;
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, gap)) begin
        tick();
        data_in_valid = 1'b0;
        if (i > 0) chk("busy_gap", int'(busy), 1);
      end
      tick();
      if (i > 0) chk("busy_mid", int'(busy), 1);
      data_in = 9'(sc[i]);
      data_in_valid = 1'b1;
    end
    tick();
    data_in_valid = 1'b0;
    chk("pulse", int'(class_out_valid), 1);
    chk("class", int'(class_out), cls);
    chk("score", int'(score_out), scr);
    chk("busy_done", int'(busy), 0);
    tick();
    chk("pulse_off", int'(class_out_valid), 0);
    chk("pulse_count", pulses - p0, 1);
  endtask

  initial begin
    int p0;
    tv[0] = '{sc: '{100, 140, 90, 200, 30, 10, 199, 0, 5, 60}, gap: 0, cls: 3, scr: 144};
    tv[1] = '{sc: '{10, 20, 150, 30, 40, 50, 60, 150, 70, 80}, gap: 0, cls: 2, scr: 44};
    tv[2] = '{sc: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, gap: 0, cls: 0, scr: -256};
    tv[3] = '{sc: '{255, 255, 255, 255, 255, 255, 255, 255, 255, 256}, gap: 0, cls: 9, scr: 256};
    tv[4] = '{sc: '{100, 140, 90, 200, 30, 10, 199, 0, 5, 60}, gap: 3, cls: 3, scr: 144};
    tv[5] = '{sc: '{250, 3, 249, 250, 1, 2, 3, 4, 5, 6}, gap: 1, cls: 0, scr: 244};
    repeat (2) tick();
    chk("rst_class", int'(class_out), 0);
    chk("rst_score", int'(score_out), 0);
    chk("rst_valid", int'(class_out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) run_frame(tv[k].sc, tv[k].gap, tv[k].cls, tv[k].scr);

    // Back-to-back: 20 consecutive scores, pulses exactly 10 cycles apart.
    p0 = pulses;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 10) begin
        chk("b2b_pulse_a", int'(class_out_valid), 1);
        chk("b2b_class_a", int'(class_out), 3);
        chk("b2b_score_a", int'(score_out), 144);
      end else if (i > 0) chk("b2b_quiet", int'(class_out_valid), 0);
      data_in = 9'(i < 10 ? tv[0].sc[i] : tv[1].sc[i-10]);
      data_in_valid = 1'b1;
    end
    tick();
    data_in_valid = 1'b0;
    chk("b2b_pulse_b", int'(class_out_valid), 1);
    chk("b2b_class_b", int'(class_out), 2);
    chk("b2b_score_b", int'(score_out), 44);
    tick();
    chk("b2b_count", pulses - p0, 2);

    // Abort after 4 high scores; the dropped score on the clear cycle must not count.
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      tick();
      data_in = 9'd255;
      data_in_valid = 1'b1;
    end
    tick();
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
    data_in_valid = 1'b0;
    chk("clr_busy", int'(busy), 0);
    chk("clr_class_held", int'(class_out), 2);
    run_frame(tv[0].sc, 0, 3, 144);
    chk("clr_count", pulses - p0, 1);

    // Clear coinciding with the completing score suppresses the pulse and keeps outputs.
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      tick();
      data_in = 9'(tv[1].sc[i]);
      data_in_valid = 1'b1;
      frame_clr = i == 9;
    end
    tick();
    frame_clr = 1'b0;
    data_in_valid = 1'b0;
    tick();
    chk("clr_last_count", pulses - p0, 0);
    chk("clr_last_class", int'(class_out), 3);
    chk("clr_last_score", int'(score_out), 144);
    chk("clr_last_busy", int'(busy), 0);

    // Reset mid-frame: outputs return to zero, no pulse, next frame starts clean.
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      tick();
      data_in = 9'(tv[3].sc[i]);
      data_in_valid = 1'b1;
    end
    tick();
    data_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_class", int'(class_out), 0);
    chk("mrst_score", int'(score_out), 0);
    chk("mrst_valid", int'(class_out_valid), 0);
    chk("mrst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("mrst_count", pulses - p0, 0);
    run_frame(tv[1].sc, 0, 2, 44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/output_argmax.md
# output_argmax

Final classification stage that sits directly downstream of the binarized output-layer popcount stage. It consumes the stream of per-class XNOR-popcount scores, one score per valid cycle and `NUM_CLASS` scores per frame. For each frame it picks the class with the highest score and emits that class index with its signed bipolar score, as a one-cycle result pulse.

## Interface
- `DATA_W`, 9: popcount score width; must hold 0..`VEC_LEN`.
- `VEC_LEN`, 256: binarized vector length that produced the scores.
- `NUM_CLASS`, 10: scores per frame; must be ≥ 1.
- `IDX_W`, 4: class index width; must satisfy 2^`IDX_W` ≥ `NUM_CLASS`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `data_in`  in  `DATA_W`  unsigned popcount score for the current class.
- `data_in_valid`  in  1  `data_in` is sampled on every edge where this is high; no backpressure.
- `frame_clr`  in  1  synchronous abort of the partial frame.
- `class_out`  out  `IDX_W`  winning class index.
- `score_out`  out  `DATA_W+1` signed  winning bipolar score.
- `class_out_valid`  out  1  one-cycle result pulse.
- `busy`  out  1  high while a frame is partially accumulated.

## Operation
- FSM states:
  - IDLE: no partial frame.
  - ACC: accumulating a frame.
- Internal registers:
  - `best` (`DATA_W`): best score so far.
  - `best_idx` (`IDX_W`): index of `best`.
  - `cnt` (`IDX_W`): index of the next expected score.
- Score accepted in IDLE, or at frame start:
  - Load `best`=`data_in`, `best_idx`=0, `cnt`=1.
  - Go to ACC, unless `NUM_CLASS`==1, in which case the frame completes immediately.
- Score accepted in ACC:
  - If `data_in` > `best` (strictly greater), load `best`=`data_in` and `best_idx`=`cnt`.
  - Ties keep the lowest index.
  - Increment `cnt`.
- Frame completes on the edge that accepts the score with index `NUM_CLASS-1`:
  - Compare that score against `best` first.
  - Register `class_out` = final `best_idx`.
  - Register `score_out` = 2·final `best` − `VEC_LEN`, computed in `DATA_W+1` bits signed.
  - Pulse `class_out_valid`; return to IDLE with `cnt`=0.
- Gaps (`data_in_valid` low) are allowed anywhere; state holds.
- `frame_clr` high: go to IDLE, set `cnt`=0, discard the partial frame.
  - It has priority over a same-cycle `data_in_valid`, which is dropped.
  - It does not alter `class_out`/`score_out`. It suppresses a completion pulse only when it coincides with the completing score.
- `busy` = (state==ACC).
- Scores > `VEC_LEN` are out of contract; no checking.

## Timing
- Reset values:
  - `class_out`=0, `score_out`=0, `class_out_valid`=0, `busy`=0.
  - State IDLE; `cnt`, `best`, `best_idx` all 0.
- Latency: `class_out_valid` is high in the cycle after the edge sampling the last score of the frame.
  - It is high for exactly one cycle unless the next frame also completes on the following edge, which is only possible with `NUM_CLASS`==1.
- `class_out`/`score_out` hold their value until the next completion.
- Back-to-back frames: a score sampled on the completing edge is not possible; the first score of the next frame may arrive on the very next edge. Zero bubble; throughput of one score per cycle.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost and no pulse is produced.
- Counter wrap: `cnt` never exceeds `NUM_CLASS-1`; it is cleared on completion.

## Structure
- Shared package `output_pkg`:
  - `VEC_LEN`, `NUM_CLASS`, `DATA_W`, `IDX_W` constants.
  - FSM state enum {IDLE, ACC}.
  - Function for bipolar conversion (2·p − `VEC_LEN`), reused by other output stages.
- No sub-module: the compare/update datapath is small and stays inline. A single combinational next-state block plus one registered always block per register group.

## Test plan
- `NUM_CLASS`=10, scores 100,140,90,200,30,10,199,0,5,60 on consecutive cycles → single pulse one cycle after the 10th score, `class_out`=3, `score_out`=+144.
- Tie: 150 at idx 2 and idx 7, all others < 150 → `class_out`=2, `score_out`=+44.
- Extremes: all scores 0 → `class_out`=0, `score_out`=−256. Score 256 at idx 9, others 255 → `class_out`=9, `score_out`=+256.
- Same frame as the first scenario with random 0–3 cycle gaps between scores → identical result; pulse exactly one cycle after the last sampled score; `busy` high from the first score until completion.
- 20 consecutive valid scores (two frames) → two pulses exactly 10 cycles apart, each with the correct per-frame winner.
- Abort and reset:
  - `frame_clr` after 4 scores, then a full 10-score frame → exactly one pulse, reflecting only the 10-score frame.
  - `rst_n` low mid-frame → all outputs 0 and no pulse.
